// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: gates the UART receiver, buffers bytes in a small
// first-word-fall-through FIFO, drops BREAK frames and flags overrun / idle timeout.
module uart_rx_ctrl #(
    parameter int PAYLOAD_BITS   = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 52080,
    parameter int CNT_W          = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              ctrl_en,
    output logic                              rx_en,
    input  logic                              rx_valid,
    input  logic                              rx_break,
    input  logic [PAYLOAD_BITS-1:0]           rx_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [PAYLOAD_BITS-1:0]           out_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              overrun,
    output logic                              break_seen,
    input  logic                              sts_clr,
    output logic                              idle_pulse
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_FW = $clog2(FIFO_DEPTH+1);
    localparam logic [CNT_W-1:0]  TIMEOUT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_FW-1:0] DEPTH   = CNT_FW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_ACTIVE,
        ST_BREAK
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic                    armed;
    logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;

    logic                    push_req;
    logic                    brk_evt;
    logic                    pop;
    logic                    full;
    logic                    push;
    logic                    drop;
    logic [PTR_W-1:0]        rd_next;
    logic [CNT_FW-1:0]       remain;
    logic [CNT_FW-1:0]       count_next;
    logic [CNT_W-1:0]        cnt_inc;

    always_comb begin
        push_req   = (state == ST_ACTIVE) && ctrl_en && rx_valid && !rx_break;
        brk_evt    = (state == ST_ACTIVE) && ctrl_en && rx_valid && rx_break;
        pop        = out_valid && out_ready;
        full       = (fifo_count == DEPTH);
        push       = push_req && (!full || pop);
        drop       = push_req && full && !pop;
        rd_next    = rd_ptr + PTR_W'(pop);
        remain     = fifo_count - CNT_FW'(pop);
        count_next = remain + CNT_FW'(push);
        cnt_inc    = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    // The head is registered from the post-update FIFO state, so out_data
    // keeps the last byte once the FIFO runs empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            overrun    <= 1'b0;
            break_seen <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr     <= rd_next;
            fifo_count <= count_next;
            out_valid  <= (count_next != '0);
            if (count_next != '0) begin
                out_data <= (remain == '0) ? rx_data : mem[rd_next];
            end
            overrun    <= drop || (overrun && !sts_clr);
            break_seen <= brk_evt || (break_seen && !sts_clr);
        end
    end

    // One counter serves as the inter-byte idle timer in ACTIVE and as the
    // quiet-line recovery timer in BREAK.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_OFF;
            rx_en      <= 1'b0;
            cnt        <= '0;
            armed      <= 1'b0;
            idle_pulse <= 1'b0;
        end else begin
            idle_pulse <= 1'b0;
            case (state)
                ST_OFF: begin
                    if (ctrl_en) begin
                        state <= ST_ACTIVE;
                        rx_en <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (!ctrl_en) begin
                        state <= ST_OFF;
                        rx_en <= 1'b0;
                        cnt   <= '0;
                        armed <= 1'b0;
                    end else if (rx_valid && rx_break) begin
                        state <= ST_BREAK;
                        cnt   <= '0;
                        armed <= 1'b0;
                    end else if (rx_valid) begin
                        armed <= 1'b1;
                        cnt   <= '0;
                    end else if (armed) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == TIMEOUT) begin
                            idle_pulse <= 1'b1;
                            armed      <= 1'b0;
                        end
                    end
                end
                ST_BREAK: begin
                    if (!ctrl_en) begin
                        state <= ST_OFF;
                        rx_en <= 1'b0;
                        cnt   <= '0;
                        armed <= 1'b0;
                    end else if (rx_valid) begin
                        cnt <= '0;
                    end else if (cnt_inc == TIMEOUT) begin
                        state <= ST_ACTIVE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= ST_OFF;
                    rx_en <= 1'b0;
                    cnt   <= '0;
                    armed <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: expected bytes are queued as stimulus is
// issued and a negedge monitor compares them whenever the consumer pops.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       ctrl_en;
    logic       rx_en;
    logic       rx_valid;
    logic       rx_break;
    logic [7:0] rx_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] fifo_count;
    logic       overrun;
    logic       break_seen;
    logic       sts_clr;
    logic       idle_pulse;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb [$];

    uart_rx_ctrl #(
        .PAYLOAD_BITS  (8),
        .FIFO_DEPTH    (4),
        .TIMEOUT_CYCLES(20),
        .CNT_W         (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ctrl_en   (ctrl_en),
        .rx_en     (rx_en),
        .rx_valid  (rx_valid),
        .rx_break  (rx_break),
        .rx_data   (rx_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .fifo_count(fifo_count),
        .overrun   (overrun),
        .break_seen(break_seen),
        .sts_clr   (sts_clr),
        .idle_pulse(idle_pulse)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic brk = 1'b0);
        rx_valid = 1'b1;
        rx_break = brk;
        rx_data  = d;
        tick();
        rx_valid = 1'b0;
        rx_break = 1'b0;
    endtask

    // Monitor: every accepted head byte must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_output("unexpected_pop", {24'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                check_output("sb_data", {24'd0, out_data}, {24'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int pulses;
        int pulse_at;

        reset     = 1'b1;
        ctrl_en   = 1'b0;
        rx_valid  = 1'b0;
        rx_break  = 1'b0;
        rx_data   = 8'h00;
        out_ready = 1'b0;
        sts_clr   = 1'b0;
        tick(3);
        reset = 1'b0;
        @(negedge clk);
        check_output("rst_rx_en", rx_en, 0);
        check_output("rst_out_valid", out_valid, 0);
        check_output("rst_count", fifo_count, 0);
        check_output("rst_overrun", overrun, 0);
        check_output("rst_break", break_seen, 0);
        check_output("rst_idle", idle_pulse, 0);
        check_output("rst_out_data", out_data, 0);

        // Enable and pass two bytes straight through
        ctrl_en = 1'b1;
        tick();
        @(negedge clk);
        check_output("t1_rx_en", rx_en, 1);
        out_ready = 1'b1;
        sb.push_back(8'h55);
        send(8'h55);
        @(negedge clk);
        check_output("t1_valid_55", out_valid, 1);
        sb.push_back(8'hA3);
        send(8'hA3);
        @(negedge clk);
        check_output("t1_valid_a3", out_valid, 1);
        tick(2);

        // Overflow: fifth byte dropped
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) sb.push_back(8'(i));
            send(8'(i));
        end
        @(negedge clk);
        check_output("t2_count_full", fifo_count, 4);
        check_output("t2_overrun", overrun, 1);
        out_ready = 1'b1;
        tick(5);
        @(negedge clk);
        check_output("t2_drained", fifo_count, 0);
        sts_clr = 1'b1;
        tick();
        sts_clr = 1'b0;
        @(negedge clk);
        check_output("t2_overrun_clr", overrun, 0);

        // Push coincident with pop while full
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(8'h10 + 8'(i));
            send(8'h10 + 8'(i));
        end
        @(negedge clk);
        check_output("t3_count_full", fifo_count, 4);
        out_ready = 1'b1;
        sb.push_back(8'h14);
        send(8'h14);
        out_ready = 1'b0;
        @(negedge clk);
        check_output("t3_count_kept", fifo_count, 4);
        check_output("t3_no_overrun", overrun, 0);
        out_ready = 1'b1;
        tick(5);
        @(negedge clk);
        check_output("t3_drained", fifo_count, 0);

        // BREAK handling and quiet-line recovery
        send(8'h00, 1'b1);
        @(negedge clk);
        check_output("t4_break_seen", break_seen, 1);
        check_output("t4_no_push", fifo_count, 0);
        tick(4);
        send(8'h77);
        @(negedge clk);
        check_output("t4_drop_77", out_valid, 0);
        tick(22);
        sb.push_back(8'h66);
        send(8'h66);
        @(negedge clk);
        check_output("t4_valid_66", out_valid, 1);
        sts_clr = 1'b1;
        tick();
        sts_clr = 1'b0;
        @(negedge clk);
        check_output("t4_break_clr", break_seen, 0);

        // Idle timeout pulse
        sb.push_back(8'h12);
        send(8'h12);
        check_output("t5_idle_early", idle_pulse, 0);
        pulses   = 0;
        pulse_at = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (idle_pulse) begin
                pulses++;
                pulse_at = k;
            end
        end
        check_output("t5_pulse_count", pulses, 1);
        check_output("t5_pulse_at", pulse_at, 20);

        // Disable with bytes queued, drain, then reset discards
        out_ready = 1'b0;
        sb.push_back(8'h21);
        send(8'h21);
        sb.push_back(8'h22);
        send(8'h22);
        ctrl_en = 1'b0;
        tick();
        @(negedge clk);
        check_output("t6_rx_en_off", rx_en, 0);
        send(8'h99);
        @(negedge clk);
        check_output("t6_count_kept", fifo_count, 2);
        out_ready = 1'b1;
        tick(4);
        @(negedge clk);
        check_output("t6_drained", fifo_count, 0);
        out_ready = 1'b0;
        ctrl_en   = 1'b1;
        tick();
        send(8'h31);
        @(negedge clk);
        check_output("t6_refill", fifo_count, 1);
        ctrl_en = 1'b0;
        reset   = 1'b1;
        tick();
        @(negedge clk);
        check_output("t6_rst_count", fifo_count, 0);
        check_output("t6_rst_valid", out_valid, 0);
        check_output("t6_rst_rx_en", rx_en, 0);
        reset = 1'b0;
        tick(2);
        check_output("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
